// File: rtl/multi_cycle_control.sv
// Main sequencing FSM for the multi-cycle MIPS core: decodes the IR opcode and drives the
// datapath enables/selects each cycle, stalling on the unified-memory ready handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 and IR load when mem_ready
// DECODE    | register read, branch target into ALUOut, opcode dispatch
// MEM_ADDR  | effective address base + imm for lw/sw
// MEM_READ  | data read, held until mem_ready
// MEM_WB    | MDR written to rt
// MEM_WRITE | data write, held until mem_ready
// R_EXEC    | funct-decoded ALU operation
// R_WB      | ALUOut written to rd
// BRANCH    | beq compare, conditional PC load from ALUOut
// JUMP      | PC <= jump target
// ADDI_EXEC | base + imm
// ADDI_WB   | ALUOut written to rt
// JAL       | $31 <= PC and PC <= jump target on the same edge
// JR        | PC <= regA

module multi_cycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        JAL       = 4'd12,
        JR        = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_done)
                count_q <= count_q + 32'd1;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

    // Reset masks the whole decode so nothing is written while rst is high.
    always_comb begin
        state_d     = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    state_d = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_RTYPE:      state_d = (funct == FN_JR) ? JR : R_EXEC;
                        OP_LW, OP_SW:  state_d = MEM_ADDR;
                        OP_BEQ:        state_d = BRANCH;
                        OP_J:          state_d = JUMP;
                        OP_JAL:        state_d = JAL;
                        OP_ADDI:       state_d = ADDI_EXEC;
                        default: begin
                            state_d    = FETCH;
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = mem_ready ? MEM_WB : MEM_READ;
                end
                MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b01;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                    state_d    = mem_ready ? FETCH : MEM_WRITE;
                end
                R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    state_d = R_WB;
                end
                R_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b01;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = ADDI_WB;
                end
                ADDI_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                JAL: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b10;
                    MemtoReg   = 2'b10;
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                JR: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b11;
                    instr_done = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle state, control-vector and retire-count
// expectations written out by hand for each instruction class.

module tb_multi_cycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg;
    logic [3:0]  state;
    logic        instr_done, illegal_op;
    logic [31:0] instr_count;

    multi_cycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,
    //  ALUSrcB,ALUOp,PCSource,RegDst,MemtoReg, instr_done,illegal_op}
    logic [19:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, instr_done, illegal_op};

    localparam logic [19:0] C_ZERO   = 20'b00000000_00_00_00_00_00_00;
    localparam logic [19:0] C_FRDY   = 20'b10010100_01_00_00_00_00_00;
    localparam logic [19:0] C_FSTALL = 20'b00010000_01_00_00_00_00_00;
    localparam logic [19:0] C_DEC    = 20'b00000000_11_00_00_00_00_00;
    localparam logic [19:0] C_DECILL = 20'b00000000_11_00_00_00_00_11;
    localparam logic [19:0] C_MADDR  = 20'b00000001_10_00_00_00_00_00;
    localparam logic [19:0] C_MREAD  = 20'b00110000_00_00_00_00_00_00;
    localparam logic [19:0] C_MWB    = 20'b00000010_00_00_00_00_01_10;
    localparam logic [19:0] C_MWRSTL = 20'b00101000_00_00_00_00_00_00;
    localparam logic [19:0] C_MWRRDY = 20'b00101000_00_00_00_00_00_10;
    localparam logic [19:0] C_REXEC  = 20'b00000001_00_10_00_00_00_00;
    localparam logic [19:0] C_RWB    = 20'b00000010_00_00_00_01_00_10;
    localparam logic [19:0] C_BRANCH = 20'b01000001_00_01_01_00_00_10;
    localparam logic [19:0] C_JUMP   = 20'b10000000_00_00_10_00_00_10;
    localparam logic [19:0] C_AEXEC  = 20'b00000001_10_00_00_00_00_00;
    localparam logic [19:0] C_AWB    = 20'b00000010_00_00_00_00_00_10;
    localparam logic [19:0] C_JAL    = 20'b10000010_00_00_10_10_10_10;
    localparam logic [19:0] C_JR     = 20'b10000000_00_00_11_00_00_10;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic [3:0]  st;
        logic [19:0] cv;
    } vec_t;

    int          nvec  = 0;
    int          nfail = 0;
    logic [31:0] exp_cnt = 32'd0;

    function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, logic mr, logic [3:0] st,
                                logic [19:0] cv);
        mk = '{op: op, fn: fn, mr: mr, st: st, cv: cv};
    endfunction

    task automatic test_reset();
        rst = 1'b1; opcode = 6'b100011; funct = 6'd0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (state !== 4'd0 || ctl !== C_ZERO || instr_count !== 32'd0) begin
            nfail++;
            $display("FAIL reset: state=%0d ctl=%b cnt=%0h, expected state=0 ctl=%b cnt=0",
                     state, ctl, instr_count, C_ZERO);
        end
        rst = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_rtype();
        vec_t v[$];
        v.push_back(mk(6'h00, 6'h20, 1'b1, 4'd0, C_FRDY));
        v.push_back(mk(6'h00, 6'h20, 1'b1, 4'd1, C_DEC));
        v.push_back(mk(6'h00, 6'h20, 1'b1, 4'd6, C_REXEC));
        v.push_back(mk(6'h00, 6'h20, 1'b1, 4'd7, C_RWB));
        v.push_back(mk(6'h00, 6'h20, 1'b0, 4'd0, C_FSTALL));
        foreach (v[i]) begin
            opcode = v[i].op; funct = v[i].fn; mem_ready = v[i].mr; #1;
            nvec++;
            if (state !== v[i].st || ctl !== v[i].cv || instr_count !== exp_cnt) begin
                nfail++;
                $display("FAIL rtype[%0d]: state=%0d ctl=%b cnt=%0h, expected state=%0d ctl=%b cnt=%0h",
                         i, state, ctl, instr_count, v[i].st, v[i].cv, exp_cnt);
            end
            if (v[i].cv[1]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_stall();
        vec_t v[$];
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd0, C_FSTALL));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd0, C_FSTALL));
        v.push_back(mk(6'h23, 6'h00, 1'b1, 4'd0, C_FRDY));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd1, C_DEC));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd2, C_MADDR));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd3, C_MREAD));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd3, C_MREAD));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd3, C_MREAD));
        v.push_back(mk(6'h23, 6'h00, 1'b1, 4'd3, C_MREAD));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd4, C_MWB));
        v.push_back(mk(6'h23, 6'h00, 1'b0, 4'd0, C_FSTALL));
        foreach (v[i]) begin
            opcode = v[i].op; funct = v[i].fn; mem_ready = v[i].mr; #1;
            nvec++;
            if (state !== v[i].st || ctl !== v[i].cv || instr_count !== exp_cnt) begin
                nfail++;
                $display("FAIL lw_stall[%0d]: state=%0d ctl=%b cnt=%0h, expected state=%0d ctl=%b cnt=%0h",
                         i, state, ctl, instr_count, v[i].st, v[i].cv, exp_cnt);
            end
            if (v[i].cv[1]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back(mk(6'h04, 6'h00, 1'b1, 4'd0,  C_FRDY));
        v.push_back(mk(6'h04, 6'h00, 1'b1, 4'd1,  C_DEC));
        v.push_back(mk(6'h04, 6'h00, 1'b1, 4'd8,  C_BRANCH));
        v.push_back(mk(6'h02, 6'h00, 1'b1, 4'd0,  C_FRDY));
        v.push_back(mk(6'h02, 6'h00, 1'b1, 4'd1,  C_DEC));
        v.push_back(mk(6'h02, 6'h00, 1'b1, 4'd9,  C_JUMP));
        v.push_back(mk(6'h03, 6'h00, 1'b1, 4'd0,  C_FRDY));
        v.push_back(mk(6'h03, 6'h00, 1'b1, 4'd1,  C_DEC));
        v.push_back(mk(6'h03, 6'h00, 1'b1, 4'd12, C_JAL));
        v.push_back(mk(6'h00, 6'h08, 1'b1, 4'd0,  C_FRDY));
        v.push_back(mk(6'h00, 6'h08, 1'b1, 4'd1,  C_DEC));
        v.push_back(mk(6'h00, 6'h08, 1'b1, 4'd13, C_JR));
        v.push_back(mk(6'h00, 6'h08, 1'b0, 4'd0,  C_FSTALL));
        foreach (v[i]) begin
            opcode = v[i].op; funct = v[i].fn; mem_ready = v[i].mr; #1;
            nvec++;
            if (state !== v[i].st || ctl !== v[i].cv || instr_count !== exp_cnt) begin
                nfail++;
                $display("FAIL back_to_back[%0d]: state=%0d ctl=%b cnt=%0h, expected state=%0d ctl=%b cnt=%0h",
                         i, state, ctl, instr_count, v[i].st, v[i].cv, exp_cnt);
            end
            if (v[i].cv[1]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_addi();
        vec_t v[$];
        v.push_back(mk(6'h2b, 6'h00, 1'b1, 4'd0,  C_FRDY));
        v.push_back(mk(6'h2b, 6'h00, 1'b1, 4'd1,  C_DEC));
        v.push_back(mk(6'h2b, 6'h00, 1'b1, 4'd2,  C_MADDR));
        v.push_back(mk(6'h2b, 6'h00, 1'b0, 4'd5,  C_MWRSTL));
        v.push_back(mk(6'h2b, 6'h00, 1'b1, 4'd5,  C_MWRRDY));
        v.push_back(mk(6'h08, 6'h00, 1'b1, 4'd0,  C_FRDY));
        v.push_back(mk(6'h08, 6'h00, 1'b0, 4'd1,  C_DEC));
        v.push_back(mk(6'h08, 6'h00, 1'b0, 4'd10, C_AEXEC));
        v.push_back(mk(6'h08, 6'h00, 1'b0, 4'd11, C_AWB));
        v.push_back(mk(6'h08, 6'h00, 1'b0, 4'd0,  C_FSTALL));
        foreach (v[i]) begin
            opcode = v[i].op; funct = v[i].fn; mem_ready = v[i].mr; #1;
            nvec++;
            if (state !== v[i].st || ctl !== v[i].cv || instr_count !== exp_cnt) begin
                nfail++;
                $display("FAIL sw_addi[%0d]: state=%0d ctl=%b cnt=%0h, expected state=%0d ctl=%b cnt=%0h",
                         i, state, ctl, instr_count, v[i].st, v[i].cv, exp_cnt);
            end
            if (v[i].cv[1]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back(mk(6'h3f, 6'h00, 1'b1, 4'd0, C_FRDY));
        v.push_back(mk(6'h3f, 6'h00, 1'b1, 4'd1, C_DECILL));
        v.push_back(mk(6'h3f, 6'h00, 1'b0, 4'd0, C_FSTALL));
        v.push_back(mk(6'h3f, 6'h00, 1'b0, 4'd0, C_FSTALL));
        foreach (v[i]) begin
            opcode = v[i].op; funct = v[i].fn; mem_ready = v[i].mr; #1;
            nvec++;
            if (state !== v[i].st || ctl !== v[i].cv || instr_count !== exp_cnt) begin
                nfail++;
                $display("FAIL illegal[%0d]: state=%0d ctl=%b cnt=%0h, expected state=%0d ctl=%b cnt=%0h",
                         i, state, ctl, instr_count, v[i].st, v[i].cv, exp_cnt);
            end
            if (v[i].cv[1]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_sw();
        opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        nvec++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            nfail++;
            $display("FAIL rst_sw_pre: state=%0d MemWrite=%b, expected state=5 MemWrite=1",
                     state, MemWrite);
        end
        rst = 1'b1; #1;
        nvec++;
        if (ctl !== C_ZERO) begin
            nfail++;
            $display("FAIL rst_sw_mask: ctl=%b, expected %b", ctl, C_ZERO);
        end
        @(posedge clk); #1;
        nvec++;
        if (state !== 4'd0 || instr_count !== 32'd0 || ctl !== C_ZERO) begin
            nfail++;
            $display("FAIL rst_sw_after: state=%0d cnt=%0h ctl=%b, expected state=0 cnt=0 ctl=%b",
                     state, instr_count, ctl, C_ZERO);
        end
        rst = 1'b0; mem_ready = 1'b1; #1;
        nvec++;
        if (state !== 4'd0 || ctl !== C_FRDY) begin
            nfail++;
            $display("FAIL rst_sw_fetch: state=%0d ctl=%b, expected state=0 ctl=%b",
                     state, ctl, C_FRDY);
        end
        exp_cnt = 32'd0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        vec_t v[$];
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        exp_cnt = 32'hFFFF_FFFF;
        v.push_back(mk(6'h08, 6'h00, 1'b1, 4'd0,  C_FRDY));
        v.push_back(mk(6'h08, 6'h00, 1'b1, 4'd1,  C_DEC));
        v.push_back(mk(6'h08, 6'h00, 1'b1, 4'd10, C_AEXEC));
        v.push_back(mk(6'h08, 6'h00, 1'b1, 4'd11, C_AWB));
        v.push_back(mk(6'h08, 6'h00, 1'b0, 4'd0,  C_FSTALL));
        foreach (v[i]) begin
            opcode = v[i].op; funct = v[i].fn; mem_ready = v[i].mr; #1;
            nvec++;
            if (state !== v[i].st || ctl !== v[i].cv || instr_count !== exp_cnt) begin
                nfail++;
                $display("FAIL wrap[%0d]: state=%0d ctl=%b cnt=%0h, expected state=%0d ctl=%b cnt=%0h",
                         i, state, ctl, instr_count, v[i].st, v[i].cv, exp_cnt);
            end
            if (v[i].cv[1]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_sw_addi();
        test_illegal();
        test_reset_mid_sw();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
